// File: rtl/teclado_pkg.sv
// Shared scan-code constants, sequencer state encoding and digit classifier
// for the keypad capture path.
package teclado_pkg;

  localparam logic [7:0] COD_BREAK  = 8'hF0;
  localparam logic [7:0] COD_EXT    = 8'hE0;
  localparam logic [7:0] COD_ESC    = 8'h76;
  localparam logic [7:0] COD_BORRAR = 8'h66;

  localparam logic [7:0] COD_0 = 8'h45;
  localparam logic [7:0] COD_1 = 8'h16;
  localparam logic [7:0] COD_2 = 8'h1E;
  localparam logic [7:0] COD_3 = 8'h26;
  localparam logic [7:0] COD_4 = 8'h25;
  localparam logic [7:0] COD_5 = 8'h2E;
  localparam logic [7:0] COD_6 = 8'h36;
  localparam logic [7:0] COD_7 = 8'h3D;
  localparam logic [7:0] COD_8 = 8'h3E;
  localparam logic [7:0] COD_9 = 8'h46;

  // Encoding doubles as the externally visible campo index.
  localparam logic [2:0] ESPERA_DEC  = 3'd0;
  localparam logic [2:0] ESPERA_UNI  = 3'd1;
  localparam logic [2:0] ESPERA_PRES = 3'd2;
  localparam logic [2:0] ESPERA_IGN  = 3'd3;
  localparam logic [2:0] LISTO       = 3'd4;

  function automatic logic es_digito(input logic [7:0] cod);
    es_digito = (cod == COD_0) || (cod == COD_1) || (cod == COD_2) ||
                (cod == COD_3) || (cod == COD_4) || (cod == COD_5) ||
                (cod == COD_6) || (cod == COD_7) || (cod == COD_8) ||
                (cod == COD_9);
  endfunction

endpackage

// File: rtl/secuenciador_captura_teclado_if.sv
// Byte stream from the PS/2 receiver plus the committed fields towards the
// decoder; slave is the sequencer, master is the receiver/consumer side.
interface secuenciador_captura_teclado_if;
  logic [7:0] dato_rx;
  logic       rx_listo;
  logic [7:0] decenas;
  logic [7:0] unidades;
  logic [7:0] presencia;
  logic [7:0] ignicion;
  logic       datos_listos;
  logic [2:0] campo;
  logic       ocupado;

  modport slave (
    input  dato_rx, rx_listo,
    output decenas, unidades, presencia, ignicion, datos_listos, campo, ocupado
  );

  modport master (
    output dato_rx, rx_listo,
    input  decenas, unidades, presencia, ignicion, datos_listos, campo, ocupado
  );
endinterface

// File: rtl/filtro_prefijos_ps2.sv
// Strips break (F0 xx) and extended (E0 xx, E0 F0 xx) sequences, leaving a
// same-cycle strobe for plain make codes only.
module filtro_prefijos_ps2
  import teclado_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dato_rx,
  input  logic       rx_listo,
  output logic       make_listo
);

  logic salto_break;
  logic salto_ext;

  // F0 is checked first so that E0 F0 xx falls into the break rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      salto_break <= 1'b0;
      salto_ext   <= 1'b0;
    end else if (rx_listo) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (dato_rx == COD_BREAK) begin
        salto_break <= 1'b1;
        salto_ext   <= 1'b0;
      end else if (salto_break) begin
        salto_break <= 1'b0;
        salto_ext   <= 1'b0;
      end else if (dato_rx == COD_EXT) begin
        salto_ext <= 1'b1;
      end else if (salto_ext) begin
        salto_ext <= 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    make_listo = 1'b0;
    if (rx_listo && !salto_break && !salto_ext &&
        dato_rx != COD_BREAK && dato_rx != COD_EXT)
      make_listo = 1'b1;
  end

endmodule

// File: rtl/secuenciador_captura_teclado.sv
// Sequences filtered make codes into DEC/UNI/PRES/IGN shadow registers and
// publishes them atomically, with Esc, Backspace and an inactivity timeout.
module secuenciador_captura_teclado
  import teclado_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  secuenciador_captura_teclado_if.slave bus
);

  localparam int CONT_ANCHO = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [CONT_ANCHO-1:0] CONT_MAX = CONT_ANCHO'(TIMEOUT_CICLOS - 1);

  logic [2:0]            estado;
  logic [2:0]            estado_ef;
  logic [7:0]            sh_dec, sh_uni, sh_pres, sh_ign;
  logic [CONT_ANCHO-1:0] cont;
  logic                  commit_r;
  logic                  make_listo;
  logic                  ocupado;
  logic                  expira;

  filtro_prefijos_ps2 u_filtro (
    .clk        (clk),
    .rst_n      (rst_n),
    .dato_rx    (bus.dato_rx),
    .rx_listo   (bus.rx_listo),
    .make_listo (make_listo)
  );

  assign ocupado = (estado == ESPERA_UNI) || (estado == ESPERA_PRES) ||
                   (estado == ESPERA_IGN);

  // A byte landing during LISTO is treated as the first byte of a new entry.
  assign estado_ef = (estado == LISTO) ? ESPERA_DEC : estado;

  // Any strobe, even a discarded prefix, counts as activity and wins over expiry.
  assign expira = ocupado && !bus.rx_listo && (cont == CONT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: async reset clears committed outputs too, not just the partial entry.
      estado           <= ESPERA_DEC;
      sh_dec           <= '0;
      sh_uni           <= '0;
      sh_pres          <= '0;
      sh_ign           <= '0;
      bus.decenas      <= '0;
      bus.unidades     <= '0;
      bus.presencia    <= '0;
      bus.ignicion     <= '0;
      commit_r         <= 1'b0;
      bus.datos_listos <= 1'b0;
      cont             <= '0;
    end else begin
      commit_r         <= (estado == LISTO);
      bus.datos_listos <= commit_r;

      if (estado == LISTO) begin
        bus.decenas   <= sh_dec;
        bus.unidades  <= sh_uni;
        bus.presencia <= sh_pres;
        bus.ignicion  <= sh_ign;
        estado        <= ESPERA_DEC;
      end

      if (make_listo) begin
        if (bus.dato_rx == COD_ESC) begin
          sh_dec  <= '0;
          sh_uni  <= '0;
          sh_pres <= '0;
          sh_ign  <= '0;
          estado  <= ESPERA_DEC;
        end else if (bus.dato_rx == COD_BORRAR) begin
          case (estado_ef)
            ESPERA_UNI:  begin sh_dec  <= '0; estado <= ESPERA_DEC;  end
            ESPERA_PRES: begin sh_uni  <= '0; estado <= ESPERA_UNI;  end
            ESPERA_IGN:  begin sh_pres <= '0; estado <= ESPERA_PRES; end
            default: ;
          endcase
        end else begin
          case (estado_ef)
            ESPERA_DEC:
              if (es_digito(bus.dato_rx)) begin
                sh_dec <= bus.dato_rx;
                estado <= ESPERA_UNI;
              end
            ESPERA_UNI:
              if (es_digito(bus.dato_rx)) begin
                sh_uni <= bus.dato_rx;
                estado <= ESPERA_PRES;
              end
            ESPERA_PRES: begin
              sh_pres <= bus.dato_rx;
              estado  <= ESPERA_IGN;
            end
            ESPERA_IGN: begin
              sh_ign <= bus.dato_rx;
              estado <= LISTO;
            end
            default: ;
          endcase
        end
      end else if (expira) begin
        sh_dec  <= '0;
        sh_uni  <= '0;
        sh_pres <= '0;
        sh_ign  <= '0;
        estado  <= ESPERA_DEC;
      end

      if (bus.rx_listo || !ocupado || expira)
        cont <= '0;
      else
        cont <= cont + CONT_ANCHO'(1);
    end
  end

  assign bus.campo   = estado;
  assign bus.ocupado = ocupado;

endmodule
